// File: rtl/regbank_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regbank_ctrl_pkg
// Description : Shared types and defaults for the register-bank operation
//               sequencer (operation codes, FSM states, width defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package regbank_ctrl_pkg;

    // Default configuration of the sequencer and the bank it drives
    localparam int c_data_w_def = 8;
    localparam int c_addr_w_def = 3;
    localparam int c_wr_lat_def = 2;

    // Operation requested by a requester: dst = src1 OP src2
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_AND = 2'd2,
        OP_OR  = 2'd3
    } op_t;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        WRITE  = 2'd2,
        SETTLE = 2'd3
    } seq_state_t;

endpackage : regbank_ctrl_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter. Combinational one-hot
//               grant; the priority pointer advances only when the owner
//               strobes i_update, handing priority to the other requester.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    // 0: requester 0 wins a tie, 1: requester 1 wins a tie
    logic r_ptr;

    // One-hot grant: a lone request always wins, a tie goes to the pointer
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_ptr ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
    end

    // Priority pointer: after serving requester k, requester 1-k is favoured
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (i_update && (o_grant != 2'b00)) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/regbank_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : regbank_op_sequencer
// Description : Shares an 8-entry register bank between two requesters. Each
//               request is a read-modify-write dst = src1 OP src2, arbitrated
//               round-robin and sequenced IDLE -> READ -> WRITE -> SETTLE so
//               every operation sees the previous result.
//               Optional build macro REGBANK_SEQ_SAT_EN: ADD saturates to
//               all-ones on carry, SUB clamps to zero on borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_op_sequencer
    import regbank_ctrl_pkg::*;
#(
    parameter int DATA_W = c_data_w_def,
    parameter int ADDR_W = c_addr_w_def,
    parameter int WR_LAT = c_wr_lat_def
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [1:0][1:0]        req_op,
    input  logic [1:0][ADDR_W-1:0] req_src1,
    input  logic [1:0][ADDR_W-1:0] req_src2,
    input  logic [1:0][ADDR_W-1:0] req_dst,
    output logic [1:0]             ack,
    output logic                   rsp_zero,
    output logic                   rsp_carry,
    output logic                   busy,
    output logic [ADDR_W-1:0]      reg_addr_1,
    output logic [ADDR_W-1:0]      reg_addr_2,
    input  logic [DATA_W-1:0]      reg_data_1,
    input  logic [DATA_W-1:0]      reg_data_2,
    output logic                   write_enable,
    output logic [ADDR_W-1:0]      write_addr,
    output logic [DATA_W-1:0]      write_data
);

    // SETTLE lasts WR_LAT-1 cycles; the counter runs 0 .. WR_LAT-2
    localparam int c_cnt_w = (WR_LAT > 2) ? $clog2(WR_LAT) : 1;
    localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'((WR_LAT > 1) ? (WR_LAT - 2) : 0);

    seq_state_t          r_state;
    seq_state_t          w_state_next;

    logic [1:0]          w_grant;
    logic                w_update;
    logic                w_sel;

    logic [1:0]          r_grant;
    op_t                 r_op;
    logic [ADDR_W-1:0]   r_src1;
    logic [ADDR_W-1:0]   r_src2;
    logic [ADDR_W-1:0]   r_dst;

    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_result;
    logic                w_carry;

    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_carry;
    logic [c_cnt_w-1:0]  r_cnt;

    logic                w_in_write;

    // A grant is taken only from IDLE; that is also when the pointer moves
    assign w_update = (r_state == IDLE) && (req != 2'b00);
    assign w_sel    = w_grant[1];

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (req),
        .i_update (w_update),
        .o_grant  (w_grant)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; WR_LAT of 1 needs no SETTLE cycle at all
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_update) w_state_next = READ;
            READ:    w_state_next = WRITE;
            WRITE:   w_state_next = (WR_LAT > 1) ? SETTLE : IDLE;
            SETTLE:  if (r_cnt == c_settle_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Latch the granted requester's fields so later changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= 2'b00;
            r_op    <= OP_ADD;
            r_src1  <= '0;
            r_src2  <= '0;
            r_dst   <= '0;
        end else if (w_update) begin
            r_grant <= w_grant;
            r_op    <= op_t'(req_op[w_sel]);
            r_src1  <= req_src1[w_sel];
            r_src2  <= req_src2[w_sel];
            r_dst   <= req_dst[w_sel];
        end
    end

    // ALU on the bank read data; carry is the raw carry/borrow in both builds
    always_comb begin
        w_sum    = {1'b0, reg_data_1} + {1'b0, reg_data_2};
        w_diff   = {1'b0, reg_data_1} - {1'b0, reg_data_2};
        w_result = '0;
        w_carry  = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_carry  = w_sum[DATA_W];
`ifdef REGBANK_SEQ_SAT_EN
                w_result = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
                w_result = w_sum[DATA_W-1:0];
`endif
            end
            OP_SUB: begin
                w_carry  = w_diff[DATA_W];
`ifdef REGBANK_SEQ_SAT_EN
                w_result = w_diff[DATA_W] ? {DATA_W{1'b0}} : w_diff[DATA_W-1:0];
`else
                w_result = w_diff[DATA_W-1:0];
`endif
            end
            OP_AND:  w_result = reg_data_1 & reg_data_2;
            OP_OR:   w_result = reg_data_1 | reg_data_2;
            default: w_result = '0;
        endcase
    end

    // Capture result and flags during READ for presentation in WRITE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
        end else if (r_state == READ) begin
            r_result <= w_result;
            r_zero   <= (w_result == '0);
            r_carry  <= w_carry;
        end
    end

    // SETTLE cycle counter, rearmed on every WRITE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == WRITE) begin
            r_cnt <= '0;
        end else if (r_state == SETTLE) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // Reset wins over a WRITE in progress so an aborted op never commits
    assign w_in_write   = (r_state == WRITE) && !rst;

    assign ack          = w_in_write ? r_grant : 2'b00;
    assign write_enable = w_in_write && (r_dst != '0);
    assign write_addr   = w_in_write ? r_dst : '0;
    assign write_data   = w_in_write ? r_result : '0;
    assign rsp_zero     = w_in_write && r_zero;
    assign rsp_carry    = w_in_write && r_carry;
    assign busy         = (r_state != IDLE);

    // Read addresses follow the latched sources and hold between operations
    assign reg_addr_1   = r_src1;
    assign reg_addr_2   = r_src2;

endmodule : regbank_op_sequencer
`default_nettype wire

// File: tb/tb_regbank_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_regbank_op_sequencer
// Description : Self-checking bench for regbank_op_sequencer with a
//               behavioural register bank (2-cycle write-to-read latency,
//               register 0 reads as zero).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_op_sequencer;

`ifdef REGBANK_SEQ_SAT_EN
    localparam bit c_sat = 1'b1;
`else
    localparam bit c_sat = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic [1:0][1:0]  req_op;
    logic [1:0][2:0]  req_src1;
    logic [1:0][2:0]  req_src2;
    logic [1:0][2:0]  req_dst;
    logic [1:0]       ack;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             busy;
    logic [2:0]       reg_addr_1;
    logic [2:0]       reg_addr_2;
    logic [7:0]       reg_data_1;
    logic [7:0]       reg_data_2;
    logic             write_enable;
    logic [2:0]       write_addr;
    logic [7:0]       write_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regbank_op_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_op       (req_op),
        .req_src1     (req_src1),
        .req_src2     (req_src2),
        .req_dst      (req_dst),
        .ack          (ack),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .busy         (busy),
        .reg_addr_1   (reg_addr_1),
        .reg_addr_2   (reg_addr_2),
        .reg_data_1   (reg_data_1),
        .reg_data_2   (reg_data_2),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data)
    );

    // Behavioural bank: one pipeline stage then the array -> readable 2 cycles after the write cycle
    logic [7:0] mem [0:7];
    logic       pl_en = 1'b0;
    logic [2:0] pl_addr = 3'd0;
    logic [7:0] pl_data = 8'd0;
    logic       d_en;
    logic [2:0] d_addr;
    logic [7:0] d_data;

    always @(posedge clk) begin
        if (pl_en && pl_addr != 3'd0) mem[pl_addr] <= pl_data;
        d_en   <= write_enable;
        d_addr <= write_addr;
        d_data <= write_data;
        if (d_en === 1'b1 && d_addr != 3'd0) mem[d_addr] <= d_data;
    end

    assign reg_data_1 = (reg_addr_1 == 3'd0) ? 8'h00 : mem[reg_addr_1];
    assign reg_data_2 = (reg_addr_2 == 3'd0) ? 8'h00 : mem[reg_addr_2];

    typedef struct {
        int         rq;
        logic [1:0] op;
        logic [2:0] s1;
        logic [2:0] s2;
        logic [2:0] d;
        logic [7:0] v1;
        logic [7:0] v2;
        logic [7:0] wd;
        logic       z;
        logic       c;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] v);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = v;
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic set_fields(input int rq, input logic [1:0] op, input logic [2:0] s1,
                              input logic [2:0] s2, input logic [2:0] d);
        req_op[rq]   = op;
        req_src1[rq] = s1;
        req_src2[rq] = s2;
        req_dst[rq]  = d;
    endtask

    task automatic wait_ack(output logic [1:0] a, output int cyc);
        a   = 2'b00;
        cyc = 0;
        while (a == 2'b00 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            a = ack;
        end
    endtask

    // One table vector: preload sources, issue, check READ / WRITE / SETTLE / IDLE and the bank
    task automatic run_vec(input int i, input vec_t v);
        logic [1:0] exp_ack;
        exp_ack = 2'(1 << v.rq);
        if (v.s1 != 3'd0) preload(v.s1, v.v1);
        if (v.s2 != 3'd0) preload(v.s2, v.v2);
        @(negedge clk);
        set_fields(v.rq, v.op, v.s1, v.s2, v.d);
        req[v.rq] = 1'b1;
        @(negedge clk);  // READ
        check($sformatf("v%0d_read_busy", i), 32'(busy), 32'(1'b1));
        check($sformatf("v%0d_read_addr", i), 32'({reg_addr_1, reg_addr_2}), 32'({v.s1, v.s2}));
        check($sformatf("v%0d_read_ack", i), 32'(ack), 32'(2'b00));
        @(negedge clk);  // WRITE
        check($sformatf("v%0d_ack", i), 32'(ack), 32'(exp_ack));
        check($sformatf("v%0d_waddr", i), 32'(write_addr), 32'(v.d));
        check($sformatf("v%0d_wdata", i), 32'(write_data), 32'(v.wd));
        check($sformatf("v%0d_we", i), 32'(write_enable), 32'(v.d != 3'd0));
        check($sformatf("v%0d_flags", i), 32'({rsp_zero, rsp_carry}), 32'({v.z, v.c}));
        req[v.rq] = 1'b0;
        @(negedge clk);  // SETTLE
        check($sformatf("v%0d_settle", i), 32'({busy, ack, write_enable}), 32'(4'b1000));
        @(negedge clk);  // IDLE
        check($sformatf("v%0d_idle", i), 32'(busy), 32'(1'b0));
        if (v.d != 3'd0) check($sformatf("v%0d_bank", i), 32'(mem[v.d]), 32'(v.wd));
    endtask

    initial begin
        logic [1:0] a;
        int         cyc;

        rst = 1'b1;
        req = 2'b00;
        for (int r = 0; r < 2; r++) set_fields(r, 2'd0, 3'd0, 3'd0, 3'd0);

        //             rq  op   s1 s2 d  v1     v2     wd                         z              c
        tbl[0] = '{0, 2'd0, 0, 0, 1, 8'h00, 8'h00, 8'h00,                     1'b1,          1'b0};
        tbl[1] = '{1, 2'd0, 2, 3, 4, 8'hF0, 8'h20, c_sat ? 8'hFF : 8'h10,    1'b0,          1'b1};
        tbl[2] = '{0, 2'd1, 6, 7, 0, 8'h03, 8'h05, c_sat ? 8'h00 : 8'hFE,    c_sat,         1'b1};
        tbl[3] = '{1, 2'd2, 2, 3, 5, 8'hF0, 8'h3C, 8'h30,                     1'b0,          1'b0};
        tbl[4] = '{0, 2'd3, 6, 7, 3, 8'h0F, 8'hA0, 8'hAF,                     1'b0,          1'b0};
        tbl[5] = '{1, 2'd1, 4, 5, 6, 8'h05, 8'h05, 8'h00,                     1'b1,          1'b0};
        tbl[6] = '{0, 2'd1, 1, 2, 7, 8'h80, 8'h01, 8'h7F,                     1'b0,          1'b0};
        tbl[7] = '{1, 2'd0, 3, 4, 2, 8'h7F, 8'h01, 8'h80,                     1'b0,          1'b0};
        tbl[8] = '{0, 2'd0, 1, 2, 1, 8'hFF, 8'h01, c_sat ? 8'hFF : 8'h00,    !c_sat,        1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              32'({ack, write_enable, write_addr, write_data, reg_addr_1, reg_addr_2, rsp_zero, rsp_carry, busy}),
              32'(0));

        for (int r = 1; r < 8; r++) preload(3'(r), 8'h00);
        preload(3'd1, 8'h55);

        for (int i = 0; i < 9; i++) run_vec(i, tbl[i]);

        // Reset during READ: no write, no ack, reset outputs, pointer cleared
        preload(3'd5, 8'h00);
        preload(3'd1, 8'h01);
        @(negedge clk);
        set_fields(0, 2'd0, 3'd5, 3'd1, 3'd5);
        set_fields(1, 2'd0, 3'd5, 3'd1, 3'd5);
        req = 2'b01;
        @(negedge clk);  // READ
        check("rst_in_read_busy", 32'(busy), 32'(1'b1));
        rst = 1'b1;
        req = 2'b00;
        check("rst_cycle_quiet", 32'({ack, write_enable}), 32'(0));
        @(negedge clk);
        check("rst_outputs",
              32'({ack, write_enable, write_addr, write_data, reg_addr_1, reg_addr_2, rsp_zero, rsp_carry, busy}),
              32'(0));
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_quiet%0d", k), 32'({ack, write_enable, busy}), 32'(0));
        end
        check("rst_no_commit", 32'(mem[5]), 32'(8'h00));

        // Both requesters held: grants alternate from requester 0, ack every 4 cycles
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(a, cyc);
            check($sformatf("rr_ack%0d", k), 32'(a), 32'((k % 2 == 0) ? 2'b01 : 2'b10));
            check($sformatf("rr_lat%0d", k), 32'(cyc), 32'((k == 0) ? 2 : 4));
            check($sformatf("rr_wdata%0d", k), 32'(write_data), 32'(k + 1));
            if (k == 3) req = 2'b00;
        end
        repeat (3) @(negedge clk);
        check("rr_bank_r5", 32'(mem[5]), 32'(8'h04));

        // dst changed after the grant must not redirect the write
        @(negedge clk);
        set_fields(0, 2'd0, 3'd1, 3'd1, 3'd2);
        req = 2'b01;
        @(negedge clk);  // READ
        req_dst[0] = 3'd6;
        @(negedge clk);  // WRITE
        check("latched_dst_ack", 32'(ack), 32'(2'b01));
        check("latched_dst_waddr", 32'(write_addr), 32'(3'd2));
        check("latched_dst_wdata", 32'(write_data), 32'(8'h02));
        req = 2'b00;
        repeat (3) @(negedge clk);
        check("latched_dst_r2", 32'(mem[2]), 32'(8'h02));
        check("latched_dst_r6", 32'(mem[6]), 32'(8'h00));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_regbank_op_sequencer
`default_nettype wire

// File: doc/regbank_op_sequencer.md
# regbank_op_sequencer

Controller that shares the 8-entry register bank (`register8_bank`) between two requesters. Each requester issues one read-modify-write operation of the form `dst = src1 OP src2`. A round-robin arbiter picks one pending request. A small FSM then drives the bank's read ports, computes the result, writes it back, and waits out the bank's write-to-read latency. This guarantees the next operation always reads up-to-date data.

## Interface
- `DATA_W`, default 8: operand and result width.
- `ADDR_W`, default 3: register address width.
- `WR_LAT`, default 2: bank write-to-read latency in cycles.

- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input [1:0]: per-requester request, held until that requester's `ack` bit.
- `req_op` input [1:0][1:0]: operation code per requester (ADD, SUB, AND, OR).
- `req_src1`, `req_src2` input [1:0][ADDR_W-1:0]: source register addresses.
- `req_dst` input [1:0][ADDR_W-1:0]: destination register address.
- `ack` output [1:0]: one-cycle completion pulse for the granted requester.
- `rsp_zero`, `rsp_carry` output 1: result flags, valid while any `ack` bit is high.
- `busy` output 1: high in every state except IDLE.
- `reg_addr_1`, `reg_addr_2` output ADDR_W: connect to the bank's read addresses.
- `reg_data_1`, `reg_data_2` input DATA_W: connect to the bank's read data (combinational).
- `write_enable` output 1: connect to the bank's write enable.
- `write_addr` output ADDR_W: connect to the bank's write address.
- `write_data` output DATA_W: connect to the bank's write data.

## Operation
- **FSM states:** IDLE → READ → WRITE → SETTLE → IDLE.
- **IDLE:**
  - If any `req` bit is high, the arbiter grants one requester and latches its op, src1, src2 and dst, then moves to READ.
  - Otherwise the FSM stays in IDLE.
- **Arbitration:**
  - Round-robin over 2 requesters; the priority pointer resets to requester 0.
  - After a grant to requester k, priority passes to requester 1-k.
  - A lone request is always granted.
- **READ:**
  - Drives `reg_addr_1`/`reg_addr_2` from the latched sources.
  - Computes the result from `reg_data_1`/`reg_data_2` and registers the result and flags.
- **Arithmetic rules:**
  - ADD: DATA_W+1-bit sum; `carry` = MSB.
  - SUB: src1 − src2; `carry` = borrow, set when src1 < src2 unsigned.
  - AND/OR: `carry` = 0.
  - `zero` is set when the DATA_W result is 0.
- **WRITE:**
  - Drives `write_addr` = dst and `write_data` = result.
  - `write_enable` = 1 only if dst ≠ 0; register 0 is hardwired to zero.
  - Pulses `ack` for the granted requester and presents the flags, regardless of dst.
- **SETTLE:** Waits WR_LAT−1 cycles (counter), then returns to IDLE.
- **Requester rule:** `req` fields must stay stable from `req` rising until `ack`; changing them earlier has no effect because the fields are latched in IDLE.
- **Same-cycle conflict:** If a requester drops `req` in the same cycle it receives `ack`, nothing special happens. If it keeps `req` high, that is treated as a new request.
- **Reset mid-operation:**
  - Return to IDLE and clear the pointer.
  - No write and no `ack` for the aborted operation.
- **Reset values:** `ack`=0, `write_enable`=0, `write_addr`=0, `write_data`=0, `reg_addr_1`/`reg_addr_2`=0, `rsp_zero`=0, `rsp_carry`=0, `busy`=0.
- **Outside READ and WRITE:** read addresses hold their last value, and `write_enable` is 0.

## Timing
- Grant at cycle t (IDLE) → READ at t+1 → WRITE at t+2 (`ack` high in t+2) → SETTLE at t+3 → IDLE at t+2+WR_LAT.
- With the default WR_LAT=2, back-to-back throughput is one operation per 4 cycles.
- A written value is readable by the next operation's READ cycle; there are no data hazards.
- `ack` is never high for more than one cycle per operation, and never for both requesters in the same cycle.

## Configuration
- `REGBANK_SEQ_SAT_EN` defined:
  - ADD clamps to all-ones on carry.
  - SUB clamps to 0 on borrow.
  - `rsp_carry` still reports the raw carry or borrow.
- Undefined: ADD and SUB wrap modulo 2^DATA_W.

## Structure
- **Package `regbank_ctrl_pkg`:** `op_t` enum (OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3), `seq_state_t` enum, default width constants and the WR_LAT default.
- **Sub-module `rr_arbiter2`:** two-requester round-robin arbiter with a registered priority pointer, an `update` strobe from the FSM and a one-hot grant output.
- ALU and FSM live in the top module.

## Test plan
- Reset, then requester 0 issues ADD r1=r0+r0 with r1 preloaded to 8'h55 → WRITE cycle drives `write_addr`=1, `write_data`=8'h00; `rsp_zero`=1; `ack`=2'b01 at t+2.
- With r2=8'hF0 and r3=8'h20, requester 1 issues ADD r4=r2+r3 → `write_data`=8'h10, `rsp_carry`=1. With the macro defined → `write_data`=8'hFF.
- Both `req` bits held continuously, each issuing ADD r5=r5+r1 with r1=1 → grants alternate 0,1,0,1; `ack` every 4 cycles; r5 reads 1,2,3,4 (proves SETTLE covers the bank latency).
- SUB with dst=0 and r6=8'h03, r7=8'h05 → `write_enable` stays 0; `ack` pulses; `rsp_carry`=1; r0 reads 0.
- `rst` asserted during READ → no `write_enable`, no `ack`; outputs at reset values the next cycle; the next grant goes to requester 0.
- Requester 0 changes `req_dst` after the grant cycle → the write uses the latched dst.
